// File: rtl/pagerank_stream_receiver.sv
// pagerank_stream_receiver
//   Collects NUM_HW_THREADS frames of NODES_IN_GRAPH Q32.32 partial-rank words,
//   sums them per node with saturation, measures the L1 distance to the
//   previously published vector, then publishes the new vector together with
//   a convergence flag and an iteration count.
//
// Ports
//   clock, reset_n            : single clock, async active-low reset
//   stream_start/valid/done   : frame open, word qualifier, frame close
//   stream_data [63:0]        : unsigned Q32.32 partial rank word
//   threshold [63:0]          : convergence bound, captured while comparing
//   stream_ready              : high while frames can be accepted
//   pagerank_sum [N][63:0]    : last published per-node sums
//   sum_valid                 : one-cycle publish pulse
//   converged                 : delta < threshold at last publish
//   iteration_number [31:0]   : number of publishes (wraps)
//   frame_error               : one-cycle protocol-violation pulse
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | between frames, waiting for stream_start
// RECV    | accumulating words of an open frame
// COMPARE | one node per cycle: delta += |acc[k] - prev[k]|
// PUBLISH | single cycle: publish sums, roll acc into prev, clear acc
module pagerank_stream_receiver #(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           stream_start,
  input  logic                           stream_valid,
  input  logic [63:0]                    stream_data,
  input  logic                           stream_done,
  input  logic [63:0]                    threshold,
  output logic                           stream_ready,
  output logic [NODES_IN_GRAPH-1:0][63:0] pagerank_sum,
  output logic                           sum_valid,
  output logic                           converged,
  output logic [31:0]                    iteration_number,
  output logic                           frame_error
);

  localparam int AW = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
  localparam int IW = $clog2(NODES_IN_GRAPH + 1);
  localparam int TW = $clog2(NUM_HW_THREADS + 1);
  localparam logic [IW-1:0] NODES_I   = IW'(NODES_IN_GRAPH);
  localparam logic [AW-1:0] LAST_NODE = AW'(NODES_IN_GRAPH - 1);
  localparam logic [TW-1:0] LAST_THR  = TW'(NUM_HW_THREADS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_COMPARE = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  state_t                            state_q, state_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic                              ovf_q, ovf_d;
  logic [TW-1:0]                     thr_cnt_q, thr_cnt_d;
  logic [NODES_IN_GRAPH-1:0][63:0]   acc_q, acc_d;
  logic [NODES_IN_GRAPH-1:0][63:0]   prev_q, prev_d;
  logic [NODES_IN_GRAPH-1:0][63:0]   sum_q, sum_d;
  logic [63:0]                       delta_q, delta_d;
  logic [63:0]                       thresh_q, thresh_d;
  logic [AW-1:0]                     cmp_idx_q, cmp_idx_d;
  logic                              conv_q, conv_d;
  logic [31:0]                       iter_q, iter_d;
  logic                              sum_valid_q, sum_valid_d;
  logic                              ferr_q, ferr_d;

  logic                              take_word;
  logic                              close_frame;
  logic [IW-1:0]                     word_idx;
  logic                              word_ovf;
  logic [IW-1:0]                     idx_after;
  logic                              ovf_after;
  logic [63:0]                       node_diff;

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    thr_cnt_d   = thr_cnt_q;
    acc_d       = acc_q;
    prev_d      = prev_q;
    sum_d       = sum_q;
    delta_d     = delta_q;
    thresh_d    = thresh_q;
    cmp_idx_d   = cmp_idx_q;
    conv_d      = conv_q;
    iter_d      = iter_q;
    sum_valid_d = 1'b0;
    ferr_d      = 1'b0;
    take_word   = 1'b0;
    close_frame = 1'b0;
    node_diff   = '0;

    // The start cycle carries word 0, so the word index restarts from zero there.
    word_idx = (state_q == ST_IDLE) ? '0 : idx_q;
    word_ovf = (state_q == ST_IDLE) ? 1'b0 : ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (stream_start) begin
          state_d     = ST_RECV;
          take_word   = stream_valid;
          close_frame = stream_done;
        end
      end
      ST_RECV: begin
        if (stream_start) ferr_d = 1'b1;
        take_word   = stream_valid;
        close_frame = stream_done;
      end
      ST_COMPARE: begin
        thresh_d  = threshold;
        node_diff = (acc_q[cmp_idx_q] >= prev_q[cmp_idx_q]) ?
                    (acc_q[cmp_idx_q] - prev_q[cmp_idx_q]) :
                    (prev_q[cmp_idx_q] - acc_q[cmp_idx_q]);
        delta_d   = sat_add(delta_q, node_diff);
        cmp_idx_d = cmp_idx_q + AW'(1);
        if (cmp_idx_q == LAST_NODE) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        sum_d       = acc_q;
        prev_d      = acc_q;
        acc_d       = '0;
        thr_cnt_d   = '0;
        conv_d      = (delta_q < thresh_q);
        iter_d      = iter_q + 32'd1;
        sum_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Index saturates at NODES_IN_GRAPH so an over-long frame still closes as "full".
    idx_after = word_idx;
    ovf_after = word_ovf;
    if (take_word) begin
      if (word_idx < NODES_I) begin
        acc_d[word_idx[AW-1:0]] = sat_add(acc_q[word_idx[AW-1:0]], stream_data);
        idx_after = word_idx + IW'(1);
      end else begin
        if (!word_ovf) ferr_d = 1'b1;
        ovf_after = 1'b1;
      end
    end
    idx_d = idx_after;
    ovf_d = ovf_after;

    if (close_frame) begin
      thr_cnt_d = thr_cnt_q + TW'(1);
      if (idx_after != NODES_I) ferr_d = 1'b1;
      if (thr_cnt_q == LAST_THR) begin
        state_d   = ST_COMPARE;
        cmp_idx_d = '0;
        delta_d   = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      thr_cnt_q   <= '0;
      acc_q       <= '0;
      prev_q      <= '0;
      sum_q       <= '0;
      delta_q     <= '0;
      thresh_q    <= '0;
      cmp_idx_q   <= '0;
      conv_q      <= 1'b0;
      iter_q      <= '0;
      sum_valid_q <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      thr_cnt_q   <= thr_cnt_d;
      acc_q       <= acc_d;
      prev_q      <= prev_d;
      sum_q       <= sum_d;
      delta_q     <= delta_d;
      thresh_q    <= thresh_d;
      cmp_idx_q   <= cmp_idx_d;
      conv_q      <= conv_d;
      iter_q      <= iter_d;
      sum_valid_q <= sum_valid_d;
      ferr_q      <= ferr_d;
    end
  end

  assign stream_ready     = (state_q == ST_IDLE) || (state_q == ST_RECV);
  assign pagerank_sum     = sum_q;
  assign sum_valid        = sum_valid_q;
  assign converged        = conv_q;
  assign iteration_number = iter_q;
  assign frame_error      = ferr_q;

endmodule

// File: tb/tb_pagerank_stream_receiver.sv
// Bench for pagerank_stream_receiver with 2 threads x 4 nodes. A
// transaction-level model predicts publish contents, publish cycle and
// frame_error cycles; a negedge process compares every cycle, and a few
// literal expectations pin the model.
module tb_pagerank_stream_receiver;
  localparam int T = 2;
  localparam int N = 4;
  typedef logic [N-1:0][63:0] vec_t;
  typedef struct {
    int          cyc;
    vec_t        sum;
    bit          conv;
    logic [31:0] iter;
  } pub_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stream_start = 1'b0;
  logic        stream_valid = 1'b0;
  logic [63:0] stream_data = '0;
  logic        stream_done = 1'b0;
  logic [63:0] threshold = '0;
  logic        stream_ready;
  vec_t        pagerank_sum;
  logic        sum_valid;
  logic        converged;
  logic [31:0] iteration_number;
  logic        frame_error;

  pagerank_stream_receiver #(.NUM_HW_THREADS(T), .NODES_IN_GRAPH(N)) dut (
    .clock(clock), .reset_n(reset_n),
    .stream_start(stream_start), .stream_valid(stream_valid),
    .stream_data(stream_data), .stream_done(stream_done),
    .threshold(threshold), .stream_ready(stream_ready),
    .pagerank_sum(pagerank_sum), .sum_valid(sum_valid),
    .converged(converged), .iteration_number(iteration_number),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // model state
  logic [63:0] m_acc [N];
  logic [63:0] m_prev[N];
  bit          m_in_frame;
  bit          m_ovf;
  int          m_idx;
  int          m_threads;
  int          m_busy_end = -100;
  int          rl_lo = -100;
  int          rl_hi = -100;
  logic [31:0] m_iter;
  bit          ferr_at[int];
  pub_t        pub_q[$];
  vec_t        exp_sum;
  bit          exp_conv;
  logic [31:0] exp_iter;

  int          dut_sv_cyc = -1;
  int          dut_ferr_cnt = 0;
  int          last_done_edge = 0;
  logic [63:0] fw[8];

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkv(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] msat(input logic [64:0] x);
    return (x > 65'h0_FFFF_FFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF_FFFF : x[63:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_acc[k]  = '0;
      m_prev[k] = '0;
    end
    m_in_frame = 0; m_ovf = 0; m_idx = 0; m_threads = 0;
    m_busy_end = -100; rl_lo = -100; rl_hi = -100;
    m_iter = '0; exp_sum = '0; exp_conv = 0; exp_iter = '0;
    ferr_at.delete();
    pub_q.delete();
  endtask

  // Inputs sampled at edge number e.
  task automatic model_apply(input bit st, input bit v, input logic [63:0] d,
                             input bit dn, input int e);
    bit          err;
    logic [63:0] dl;
    logic [63:0] df;
    pub_t        p;
    err = 0;
    if (e <= m_busy_end) return;
    if (!m_in_frame) begin
      if (!st) return;
      m_in_frame = 1; m_idx = 0; m_ovf = 0;
    end else if (st) begin
      err = 1;
    end
    if (v) begin
      if (m_idx < N) begin
        m_acc[m_idx] = msat({1'b0, m_acc[m_idx]} + {1'b0, d});
        m_idx++;
      end else begin
        if (!m_ovf) err = 1;
        m_ovf = 1;
      end
    end
    if (dn) begin
      if (m_idx != N) err = 1;
      m_in_frame = 0;
      m_threads++;
      if (m_threads == T) begin
        dl = '0;
        for (int k = 0; k < N; k++) begin
          df = (m_acc[k] >= m_prev[k]) ? m_acc[k] - m_prev[k] : m_prev[k] - m_acc[k];
          dl = msat({1'b0, dl} + {1'b0, df});
        end
        m_iter = m_iter + 32'd1;
        p.cyc  = e + N + 1;
        for (int k = 0; k < N; k++) p.sum[k] = m_acc[k];
        p.conv = (dl < threshold);
        p.iter = m_iter;
        pub_q.push_back(p);
        for (int k = 0; k < N; k++) begin
          m_prev[k] = m_acc[k];
          m_acc[k]  = '0;
        end
        m_threads  = 0;
        m_busy_end = e + N + 1;
        rl_lo      = e;
        rl_hi      = e + N;
      end
    end
    if (err) ferr_at[e] = 1;
  endtask

  always @(negedge clock) begin
    bit esv;
    if (reset_n) begin
      while (pub_q.size() > 0 && pub_q[0].cyc < cyc) void'(pub_q.pop_front());
      esv = (pub_q.size() > 0) && (pub_q[0].cyc == cyc);
      if (esv) begin
        exp_sum  = pub_q[0].sum;
        exp_conv = pub_q[0].conv;
        exp_iter = pub_q[0].iter;
        void'(pub_q.pop_front());
      end
      if (sum_valid) dut_sv_cyc = cyc;
      if (frame_error) dut_ferr_cnt++;
      chk64("sum_valid", 64'(sum_valid), 64'(esv));
      chk64("frame_error", 64'(frame_error), 64'(ferr_at.exists(cyc)));
      chk64("stream_ready", 64'(stream_ready), 64'(!(cyc >= rl_lo && cyc <= rl_hi)));
      chkv("pagerank_sum", pagerank_sum, exp_sum);
      chk64("converged", 64'(converged), 64'(exp_conv));
      chk64("iteration_number", 64'(iteration_number), 64'(exp_iter));
    end
  end

  task automatic step(input bit st, input bit v, input logic [63:0] d, input bit dn);
    @(negedge clock);
    #1;
    stream_start = st;
    stream_valid = v;
    stream_data  = d;
    stream_done  = dn;
    model_apply(st, v, d, dn, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0, 0);
  endtask

  // Words fw[0..n-1]; done rides on the last word; extra start at index start_at.
  task automatic send_frame(input int n, input int start_at);
    for (int i = 0; i < n; i++) begin
      step((i == 0) || (i == start_at), 1, fw[i], i == n - 1);
      if (i == n - 1) last_done_edge = cyc + 1;
    end
  endtask

  task automatic set4(input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [63:0] d);
    fw[0] = a; fw[1] = b; fw[2] = c; fw[3] = d;
  endtask

  task automatic two_frames_std();
    set4(64'h1_0000_0000, 64'h2_0000_0000, 64'h3_0000_0000, 64'h4_0000_0000);
    send_frame(4, -1);
    set4(64'hA_0000_0000, 64'h14_0000_0000, 64'h1E_0000_0000, 64'h28_0000_0000);
    send_frame(4, -1);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    stream_start = 0; stream_valid = 0; stream_done = 0; stream_data = '0;
    model_reset();
    dut_sv_cyc = -1;
    #1;
    chk64("rst_sum_valid", 64'(sum_valid), 64'd0);
    chk64("rst_iteration", 64'(iteration_number), 64'd0);
    chkv("rst_pagerank_sum", pagerank_sum, '0);
    chk64("rst_converged", 64'(converged), 64'd0);
    chk64("rst_frame_error", 64'(frame_error), 64'd0);
    chk64("rst_ready", 64'(stream_ready), 64'd1);
    repeat (hold) @(negedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    int ferr_base;
    model_reset();
    do_reset(3);

    // valid/done without a start are ignored
    step(0, 1, 64'h5_0000_0000, 1);
    step(0, 0, '0, 1);
    idle(2);

    // first iteration: sums {11,22,33,44}, delta 110 < 200
    threshold = 64'hC8_0000_0000;
    two_frames_std();
    idle(8);
    chk64("latency", 64'(dut_sv_cyc - last_done_edge), 64'd5);
    chk64("it1_sum3", pagerank_sum[3], 64'h2C_0000_0000);
    chk64("it1_sum0", pagerank_sum[0], 64'hB_0000_0000);
    chk64("it1_conv", 64'(converged), 64'd1);
    chk64("it1_iter", 64'(iteration_number), 64'd1);

    // identical iteration, threshold 0: delta 0 is not < 0; inputs during COMPARE ignored
    threshold = '0;
    two_frames_std();
    step(1, 1, 64'h7_0000_0000, 1);
    step(1, 1, 64'h7_0000_0000, 0);
    idle(8);
    chk64("it2_conv", 64'(converged), 64'd0);
    chk64("it2_iter", 64'(iteration_number), 64'd2);
    chk64("it2_sum1", pagerank_sum[1], 64'h16_0000_0000);

    threshold = 64'd1;
    two_frames_std();
    idle(8);
    chk64("it3_conv", 64'(converged), 64'd1);
    chk64("it3_iter", 64'(iteration_number), 64'd3);

    // short frame of 3 words, then a full frame of ones
    threshold = 64'hFFFF_0000_0000;
    ferr_base = dut_ferr_cnt;
    set4(64'h1_0000_0000, 64'h2_0000_0000, 64'h3_0000_0000, 0);
    send_frame(3, -1);
    set4(64'h1_0000_0000, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1_0000_0000);
    send_frame(4, -1);
    idle(8);
    chk64("short_ferr_cnt", 64'(dut_ferr_cnt - ferr_base), 64'd1);
    chk64("short_sum3", pagerank_sum[3], 64'h1_0000_0000);
    chk64("short_sum0", pagerank_sum[0], 64'h2_0000_0000);

    // 6-word frame with a stray start at word 2: one start error, one overflow error
    ferr_base = dut_ferr_cnt;
    set4(64'h1_0000_0000, 64'h2_0000_0000, 64'h3_0000_0000, 64'h4_0000_0000);
    fw[4] = 64'h63_0000_0000;
    fw[5] = 64'h63_0000_0000;
    send_frame(6, 2);
    set4(0, 0, 0, 0);
    send_frame(4, -1);
    idle(8);
    chk64("long_ferr_cnt", 64'(dut_ferr_cnt - ferr_base), 64'd2);
    chk64("long_sum3", pagerank_sum[3], 64'h4_0000_0000);

    // saturation on node 0
    set4(64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0);
    send_frame(4, -1);
    set4(64'h20, 0, 0, 0);
    send_frame(4, -1);
    idle(8);
    chk64("sat_sum0", pagerank_sum[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk64("sat_sum1", pagerank_sum[1], 64'd0);

    // reset in the middle of COMPARE
    threshold = 64'hC8_0000_0000;
    two_frames_std();
    idle(2);
    do_reset(2);
    idle(8);
    chk64("rst_no_publish", 64'(dut_sv_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    two_frames_std();
    idle(8);
    chk64("post_rst_iter", 64'(iteration_number), 64'd1);
    chk64("post_rst_sum2", pagerank_sum[2], 64'h21_0000_0000);
    chk64("post_rst_conv", 64'(converged), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pagerank_stream_receiver.md
PAGERANK_STREAM_RECEIVER -- requirements
Module: pagerank_stream_receiver

Interface
REQ-001 SHALL have parameter NUM_HW_THREADS, default 8, number of thread frames per iteration.
REQ-002 SHALL have parameter NODES_IN_GRAPH, default 32, words per frame and size of the rank vector.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stream_start  input  1  one-cycle pulse that opens a thread frame.
REQ-006 SHALL have port stream_valid  input  1  qualifies stream_data.
REQ-007 SHALL have port stream_data  input  64  unsigned Q32.32 partial rank word.
REQ-008 SHALL have port stream_done  input  1  one-cycle pulse that closes the current frame.
REQ-009 SHALL have port threshold  input  64  Q32.32 convergence bound, sampled in COMPARE.
REQ-010 SHALL have port stream_ready  output  1  high only in IDLE and RECV.
REQ-011 SHALL have port pagerank_sum  output  64 x NODES_IN_GRAPH  published per-node sums.
REQ-012 SHALL have port sum_valid  output  1  one-cycle publish pulse.
REQ-013 SHALL have port converged  output  1  delta < threshold at last publish.
REQ-014 SHALL have port iteration_number  output  32  count of publishes.
REQ-015 SHALL have port frame_error  output  1  one-cycle protocol-violation pulse.

Function
REQ-016 SHALL implement states IDLE, RECV, COMPARE, PUBLISH; reset state IDLE.
REQ-017 In IDLE, stream_start SHALL enter RECV and clear word index to 0; stream_valid/stream_done without start SHALL be ignored.
REQ-018 In RECV, each stream_valid cycle SHALL add stream_data into acc[index] with saturation at 2^64-1 and increment index; this includes the stream_start cycle, whose word is word 0.
REQ-019 Words with index >= NODES_IN_GRAPH SHALL be discarded and raise frame_error once per frame.
REQ-020 stream_done in RECV SHALL accept a same-cycle valid word first, then close the frame and increment thread_count.
REQ-021 On close, index != NODES_IN_GRAPH (short frame) SHALL pulse frame_error; missing words contribute zero.
REQ-022 stream_start in RECV (no intervening done) SHALL be ignored and pulse frame_error.
REQ-023 Closing frame NUM_HW_THREADS SHALL go to COMPARE; otherwise to IDLE.
REQ-024 COMPARE SHALL take exactly NODES_IN_GRAPH cycles, one node k per cycle, adding |acc[k]-prev[k]| into a saturating 64-bit delta.
REQ-025 PUBLISH SHALL last one cycle; on entry: pagerank_sum<=acc, prev<=acc, acc<=0, thread_count<=0, converged<=(delta<threshold, strict), iteration_number+=1 (wraps at 2^32), sum_valid=1; then IDLE.
REQ-026 sum_valid SHALL assert NODES_IN_GRAPH+1 cycles after the edge sampling the final stream_done.
REQ-027 Inputs in COMPARE/PUBLISH SHALL be ignored without frame_error; stream_ready=0 there.
REQ-028 pagerank_sum and converged SHALL hold between publishes.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, and clear acc, prev, delta, index, thread_count, pagerank_sum, iteration_number, sum_valid, converged, frame_error; stream_ready=1 after release.
REQ-030 Reset mid-frame or mid-COMPARE SHALL discard all partial work; first iteration after reset compares against prev=0.

Verification (bench: NUM_HW_THREADS=2, NODES_IN_GRAPH=4)
REQ-031 Two full frames {1,2,3,4}, {10,20,30,40} (integer parts), threshold 200.0 -> sum_valid 5 cycles after 2nd done, pagerank_sum={11,22,33,44}, converged=1 (delta 110), iteration_number=1.
REQ-032 Repeat identical iteration with threshold 0 -> converged=0; threshold 1 LSB -> converged=1 (delta 0).
REQ-033 Frame of 3 words then done -> frame_error pulse, acc[3] gets 0, thread counted, publish still occurs after second frame.
REQ-034 Frame with 5 valid words -> 5th discarded, single frame_error pulse; stream_start during RECV -> frame_error, frame continues.
REQ-035 Word 0xFFFF_FFFF_FFFF_FFF0 plus 0x20 on same node -> saturates to 0xFFFF_FFFF_FFFF_FFFF.
REQ-036 reset_n asserted during COMPARE -> no sum_valid, outputs zero, next complete iteration publishes iteration_number=1.
